pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Sequences the five-stage pipeline registers: it drives the stall and flush controls of the fetch/decode, decode/execute, execute/memory and memory/writeback pipes, and the EX-stage forwarding selects. It resolves load-use hazards, branch/jump redirects and multi-cycle data-memory waits. A small state machine covers post-reset bubbling and memory-wait tracking, including timeout detection. Sits beside the datapath; takes register addresses and control bits from the pipe outputs.

## Interface
- DATA_WIDTH, 32, datapath width (kept for package consistency)
- CNT_WIDTH, 32, width of performance counters
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before error; 8-bit wait counter

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5 each  source regs of instruction in ID
- Rs1E, Rs2E, RdE  in  5 each  regs of instruction in EX
- MemReadE  in  1  EX instruction is a load
- PCSrcE  in  1  branch taken / jump resolved in EX
- RdM, RdW  in  5 each  destination regs in MEM / WB
- RegWriteM, RegWriteW  in  1 each  write enables in MEM / WB
- MemReqM  in  1  MEM instruction accesses data memory
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold PC / respective pipe
- FlushD, FlushE, FlushW  out  1 each  insert bubble into D / E / W pipe
- ForwardAE, ForwardBE  out  2 each  00 regfile, 10 from MEM, 01 from WB
- MemTimeoutErr  out  1  sticky timeout flag
- LoadUseCnt, RedirectCnt, MemWaitCnt  out  CNT_WIDTH each  perf counters

## Operation
- States: INIT, RUN, MEM_WAIT.
- INIT:
  - FlushD=FlushE=1, all stalls 0.
  - Next state RUN unconditionally; lasts exactly one cycle after reset release.
- Freeze condition: MemReqM && !MemReadyM, evaluated in RUN or MEM_WAIT.
  - StallF=StallD=StallE=StallM=1, FlushW=1.
  - FlushD=FlushE=0.
  - Load-use and redirect are suppressed; they re-evaluate when the freeze ends.
- Redirect (no freeze): PCSrcE=1 drives FlushD=FlushE=1 and StallF=StallD=0. Takes priority over load-use.
- Load-use (no freeze, no redirect):
  - Condition: MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - Response: StallF=StallD=1, FlushE=1.
- Otherwise all stall/flush outputs 0.
- Forwarding (combinational, independent of state):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE is identical using Rs2E.
- Transitions:
  - RUN→MEM_WAIT when freeze.
  - MEM_WAIT→RUN on the cycle MemReadyM=1. The freeze is already released that cycle, since the freeze term is false.
- Wait counter:
  - Clears on entry to MEM_WAIT and increments each MEM_WAIT cycle, saturating at 255.
  - When it reaches MEM_TIMEOUT, MemTimeoutErr sets. The freeze continues.
  - MemTimeoutErr clears only on reset.
- Perf counters saturate at all-ones. Each increments once per cycle:
  - LoadUseCnt: load-use stall cycles.
  - RedirectCnt: redirect cycles.
  - MemWaitCnt: freeze cycles.

## Timing
- All stall/flush/forward outputs are combinational from current inputs and state, with zero latency. Pipes sample them at the next edge.
- State, wait counter, error flag and perf counters update on rising clk.
- Reset asserted (async): state=INIT immediately, so FlushD=FlushE=1 and stalls 0. Counters=0, MemTimeoutErr=0.
- Reset asserted mid-MEM_WAIT: freeze drops immediately and state goes to INIT. Memory-side cleanup is the memory's responsibility.
- MemReqM with MemReadyM=1 in the same cycle: no freeze and no MEM_WAIT entry (single-cycle access).
- Freeze and PCSrcE simultaneous: freeze wins. The redirect flush occurs on the first non-frozen cycle, because E is held and PCSrcE persists.

## Configuration
- HAZARD_PERF_EN defined: the three perf counters are implemented as described.
- HAZARD_PERF_EN undefined: the counter ports remain, tied to 0, with no counter flops.

## Structure
- Shared package `hazard_pkg`:
  - State enum (INIT, RUN, MEM_WAIT).
  - Forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, `forward_sel`:
  - Combinational.
  - Instantiated twice, for the A and B operands.
  - Inputs: RsE, RdM, RegWriteM, RdW, RegWriteW.
  - Output: the 2-bit select.

## Test plan
- Reset release → FlushD=FlushE=1 for exactly one cycle, then all 0 in RUN. Counters 0.
- Load x5 in EX (MemReadE=1, RdE=5), Rs2D=5 → StallF=StallD=FlushE=1 for one cycle; LoadUseCnt=1. Same case with RdE=0 → no stall.
- PCSrcE=1 together with load-use condition → FlushD=FlushE=1, StallF=0; RedirectCnt=1, LoadUseCnt unchanged.
- MemReqM=1, MemReadyM=0 for 3 cycles, then 1 → all stalls and FlushW high for 3 cycles, low on the ready cycle; MemWaitCnt=3; state returns to RUN.
- RdM=RdW=7, both RegWrite=1, Rs1E=7 → ForwardAE=10. With RegWriteM=0 → ForwardAE=01. With Rs1E=0 → ForwardAE=00.
- MEM_TIMEOUT=4, MemReadyM held 0 → MemTimeoutErr rises after the 4th wait cycle and stays set after ready. rst_n low mid-wait → error clears, INIT flush is seen.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | hazard_pkg : shared types and constants for the pipeline hazard control |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl_if : pipe-side register/control bits and controls   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pipeline_hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic                 MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic                 StallF, StallD, StallE, StallM;
  logic                 FlushD, FlushE, FlushW;
  logic [1:0]           ForwardAE, ForwardBE;
  logic                 MemTimeoutErr;
  logic [CNT_WIDTH-1:0] LoadUseCnt, RedirectCnt, MemWaitCnt;

  // Datapath side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, MemTimeoutErr,
    input  LoadUseCnt, RedirectCnt, MemWaitCnt
  );

  // Hazard controller side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  MemReadE, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, MemTimeoutErr,
    output LoadUseCnt, RedirectCnt, MemWaitCnt
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// +--------------------------------------------------------------------------+
// | forward_sel : EX operand bypass select, MEM result preferred over WB     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module forward_sel
  import hazard_pkg::*;
(
  input  wire logic [4:0] RsE_i,
  input  wire logic [4:0] RdM_i,
  input  wire logic       RegWriteM_i,
  input  wire logic [4:0] RdW_i,
  input  wire logic       RegWriteW_i,
  output logic      [1:0] Fwd_o
);

  always_comb begin
    Fwd_o = FWD_REG;
    if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == RsE_i)) begin
      Fwd_o = FWD_MEM;
    end else if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == RsE_i)) begin
      Fwd_o = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | pipeline_hazard_ctrl : stall/flush/forward sequencing for a 5-stage pipe |
// | Optional perf counters enabled by defining HAZARD_PERF_EN.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input wire logic             clk,
  input wire logic             rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q;
  logic       w_freeze, w_load_use, w_redirect_act, w_load_use_act;

  assign w_freeze   = (state_q != INIT) && hz.MemReqM && !hz.MemReadyM;
  assign w_load_use = hz.MemReadE && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  assign w_redirect_act = (state_q != INIT) && !w_freeze && hz.PCSrcE;
  assign w_load_use_act = (state_q != INIT) && !w_freeze && !hz.PCSrcE && w_load_use;

  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (state_q == INIT) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (w_freeze) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (w_load_use) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  // First freeze cycle is taken in RUN, so entry loads 1 to count it
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      INIT:     state_d = RUN;
      RUN: begin
        if (w_freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!w_freeze) begin
          state_d = RUN;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default:  state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (w_freeze && (wait_cnt_d == C_TIMEOUT)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign hz.MemTimeoutErr = err_q;

  forward_sel u_fwd_a (
    .RsE_i       (hz.Rs1E),
    .RdM_i       (hz.RdM),
    .RegWriteM_i (hz.RegWriteM),
    .RdW_i       (hz.RdW),
    .RegWriteW_i (hz.RegWriteW),
    .Fwd_o       (hz.ForwardAE)
  );

  forward_sel u_fwd_b (
    .RsE_i       (hz.Rs2E),
    .RdM_i       (hz.RdM),
    .RegWriteM_i (hz.RegWriteM),
    .RdW_i       (hz.RdW),
    .RegWriteW_i (hz.RegWriteW),
    .Fwd_o       (hz.ForwardBE)
  );

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] lu_cnt_q, rd_cnt_q, mw_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q <= '0;
      rd_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      if (w_load_use_act && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 1'b1;
      if (w_redirect_act && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
      if (w_freeze       && (mw_cnt_q != '1)) mw_cnt_q <= mw_cnt_q + 1'b1;
    end
  end

  assign hz.LoadUseCnt  = lu_cnt_q;
  assign hz.RedirectCnt = rd_cnt_q;
  assign hz.MemWaitCnt  = mw_cnt_q;
`else
  assign hz.LoadUseCnt  = '0;
  assign hz.RedirectCnt = '0;
  assign hz.MemWaitCnt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl : directed self-checking bench                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_INIT   = 7'b0000110;
  localparam logic [6:0] C_FREEZE = 7'b1111001;
  localparam logic [6:0] C_REDIR  = 7'b0000110;
  localparam logic [6:0] C_LDUSE  = 7'b1100010;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pipeline_hazard_ctrl_if #(.CNT_WIDTH(32)) hif ();

  pipeline_hazard_ctrl #(
    .DATA_WIDTH  (32),
    .CNT_WIDTH   (32),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire logic [6:0] ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM,
                          hif.FlushD, hif.FlushE, hif.FlushW};

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string name, input logic [6:0] exp);
    n_vec++;
    if (ctl !== exp) begin
      n_err++;
      $display("FAIL %s: ctl got %b want %b", name, ctl, exp);
    end
  endtask

  task automatic clear_inputs();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
    hif.RdE = 0;  hif.RdM = 0;  hif.RdW = 0;
    hif.MemReadE = 0; hif.PCSrcE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    hif.MemReqM = 0;  hif.MemReadyM = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk_ctl("reset_async", C_INIT);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk_ctl("init_cycle", C_INIT);
    n_vec++;
    if ({hif.LoadUseCnt, hif.RedirectCnt, hif.MemWaitCnt, hif.MemTimeoutErr} !== 97'd0) begin
      n_err++;
      $display("FAIL reset_counters: got %0d/%0d/%0d err=%b want 0",
               hif.LoadUseCnt, hif.RedirectCnt, hif.MemWaitCnt, hif.MemTimeoutErr);
    end
    step();
    chk_ctl("run_idle", C_IDLE);
    step();
    chk_ctl("run_idle2", C_IDLE);
  endtask

  task automatic test_load_use();
    hif.MemReadE = 1; hif.RdE = 5; hif.Rs2D = 5;
    #1;
    chk_ctl("load_use", C_LDUSE);
    step();
    clear_inputs();
    #1;
    chk_ctl("load_use_clear", C_IDLE);
    n_vec++;
    if (hif.LoadUseCnt !== pexp(1)) begin
      n_err++;
      $display("FAIL load_use_cnt: got %0d want %0d", hif.LoadUseCnt, pexp(1));
    end
    hif.MemReadE = 1; hif.RdE = 0; hif.Rs1D = 0; hif.Rs2D = 0;
    #1;
    chk_ctl("load_use_x0", C_IDLE);
    step();
    clear_inputs();
    n_vec++;
    if (hif.LoadUseCnt !== pexp(1)) begin
      n_err++;
      $display("FAIL load_use_x0_cnt: got %0d want %0d", hif.LoadUseCnt, pexp(1));
    end
  endtask

  task automatic test_redirect();
    hif.MemReadE = 1; hif.RdE = 5; hif.Rs2D = 5; hif.PCSrcE = 1;
    #1;
    chk_ctl("redirect_over_lu", C_REDIR);
    step();
    clear_inputs();
    #1;
    n_vec++;
    if ({hif.RedirectCnt, hif.LoadUseCnt} !== {pexp(1), pexp(1)}) begin
      n_err++;
      $display("FAIL redirect_cnt: got rd=%0d lu=%0d want rd=%0d lu=%0d",
               hif.RedirectCnt, hif.LoadUseCnt, pexp(1), pexp(1));
    end
  endtask

  task automatic test_mem_wait();
    hif.MemReqM = 1; hif.MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl($sformatf("mem_freeze_%0d", i), C_FREEZE);
      step();
    end
    hif.MemReadyM = 1;
    #1;
    chk_ctl("mem_ready", C_IDLE);
    step();
    n_vec++;
    if ({hif.MemWaitCnt, hif.MemTimeoutErr} !== {pexp(3), 1'b0}) begin
      n_err++;
      $display("FAIL mem_wait_cnt: got %0d err=%b want %0d err=0",
               hif.MemWaitCnt, hif.MemTimeoutErr, pexp(3));
    end
    // single-cycle access: ready with request
    #1;
    chk_ctl("mem_single_cycle", C_IDLE);
    step();
    // freeze and redirect together: freeze first, redirect once released
    hif.MemReadyM = 0; hif.PCSrcE = 1;
    #1;
    chk_ctl("freeze_over_redirect", C_FREEZE);
    step();
    hif.MemReadyM = 1;
    #1;
    chk_ctl("redirect_after_freeze", C_REDIR);
    step();
    clear_inputs();
    #1;
    n_vec++;
    if ({hif.MemWaitCnt, hif.RedirectCnt} !== {pexp(4), pexp(2)}) begin
      n_err++;
      $display("FAIL mixed_cnts: got mw=%0d rd=%0d want mw=%0d rd=%0d",
               hif.MemWaitCnt, hif.RedirectCnt, pexp(4), pexp(2));
    end
  endtask

  task automatic test_forward();
    logic [3:0] got;
    logic [3:0] want [4] = '{4'b1010, 4'b0101, 4'b0001, 4'b1000};
    hif.RdM = 7; hif.RdW = 7; hif.RegWriteM = 1; hif.RegWriteW = 1;
    hif.Rs1E = 7; hif.Rs2E = 7;
    for (int i = 0; i < 4; i++) begin
      case (i)
        1: hif.RegWriteM = 0;
        2: hif.Rs1E = 0;
        3: begin hif.RegWriteM = 1; hif.RdW = 0; hif.Rs1E = 7; hif.Rs2E = 3; end
        default: ;
      endcase
      #1;
      got = {hif.ForwardAE, hif.ForwardBE};
      n_vec++;
      if (got !== want[i]) begin
        n_err++;
        $display("FAIL forward_%0d: got AE/BE=%b want %b", i, got, want[i]);
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    hif.MemReqM = 1; hif.MemReadyM = 0;
    step(); step();
    n_vec++;
    if (hif.MemTimeoutErr !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: got %b want 0", hif.MemTimeoutErr);
    end
    repeat (5) step();
    n_vec++;
    if (hif.MemTimeoutErr !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_set: got %b want 1", hif.MemTimeoutErr);
    end
    chk_ctl("timeout_still_frozen", C_FREEZE);
    hif.MemReadyM = 1;
    step();
    clear_inputs();
    #1;
    chk_ctl("timeout_released", C_IDLE);
    n_vec++;
    if (hif.MemTimeoutErr !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b want 1", hif.MemTimeoutErr);
    end
    hif.MemReqM = 1;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk_ctl("reset_mid_wait", C_INIT);
    n_vec++;
    if (hif.MemTimeoutErr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_err_clear: got %b want 0", hif.MemTimeoutErr);
    end
    step();
    rst_n = 1'b1;
    clear_inputs();
    #1;
    chk_ctl("init_after_reset", C_INIT);
    step();
    chk_ctl("run_after_reset", C_IDLE);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_forward();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
